// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared definitions for the matrix row scanner: FSM states and width helpers.
package matrix_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLNK  = 2'd1,
      DRIVE = 2'd2
   } scan_state_e;

   // Bits needed to hold values 0..n-1; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/matrix_row_decode.sv
// One-hot row driver: selects row idx when drive is high, with optional active-low output.
module matrix_row_decode
   import matrix_scan_ctrl_pkg::*;
#(
   parameter int unsigned ROWS        = 8,
   parameter bit          ROW_ACT_LOW = 1'b0
) (
   input  logic [idx_w(ROWS)-1:0] idx,
   input  logic                   drive,
   output logic [ROWS-1:0]        sel
);

   localparam int unsigned RW = idx_w(ROWS);

   logic [ROWS-1:0] onehot;

   // Compare against every row so an out-of-range index can never light a bit.
   always_comb begin
      onehot = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         onehot[i] = drive && (idx == RW'(i));
      end
   end

   assign sel = ROW_ACT_LOW ? ~onehot : onehot;

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row scanner for a multiplexed matrix: blanking gap, then one row driven per slot.
module matrix_scan_ctrl
   import matrix_scan_ctrl_pkg::*;
#(
   parameter int unsigned ROWS        = 8,
   parameter int unsigned COL_GRPS    = 4,
   parameter int unsigned DWELL       = 16,
   parameter int unsigned BLANK       = 2,
   parameter bit          ROW_ACT_LOW = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   output logic [idx_w(ROWS)-1:0]     row_idx,
   output logic [ROWS-1:0]            row_sel,
   output logic [idx_w(COL_GRPS)-1:0] col_grp,
   output logic                       blank,
   output logic                       frame_start
);

   localparam int unsigned RW           = idx_w(ROWS);
   localparam int unsigned GW           = idx_w(COL_GRPS);
   localparam int unsigned CW           = idx_w(max_u(DWELL, BLANK));
   localparam int unsigned ROWS_PER_GRP = ROWS / COL_GRPS;
   localparam bit          NO_BLANK     = (BLANK == 0);
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

   scan_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_idx_q, row_idx_d;
   logic          blank_q, blank_d;
   logic          frame_start_q, frame_start_d;

   // Next state, slot counter and row index; en low collapses everything to idle.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_idx_d = row_idx_q;
      if (!en) begin
         state_d   = IDLE;
         cnt_d     = '0;
         row_idx_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d     = '0;
               row_idx_d = '0;
               state_d   = NO_BLANK ? DRIVE : BLNK;
            end
            BLNK: begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_d   = '0;
                  state_d = DRIVE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DRIVE: begin
               if (cnt_q == DWELL_LAST) begin
                  cnt_d     = '0;
                  row_idx_d = (row_idx_q == ROW_LAST) ? '0 : row_idx_q + RW'(1);
                  state_d   = NO_BLANK ? DRIVE : BLNK;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d   = IDLE;
               cnt_d     = '0;
               row_idx_d = '0;
            end
         endcase
      end
   end

   // Registered flags; a new drive slot starts on entering DRIVE or on a row change within DRIVE.
   always_comb begin
      blank_d       = (state_d != DRIVE);
      frame_start_d = (state_d == DRIVE) &&
                      ((state_q != DRIVE) || (cnt_q == DWELL_LAST)) &&
                      (row_idx_d == '0);
   end

   // State register with synchronous reset taking priority over en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         row_idx_q     <= '0;
         blank_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         row_idx_q     <= row_idx_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign row_idx     = row_idx_q;
   assign blank       = blank_q;
   assign frame_start = frame_start_q;
   assign col_grp     = GW'(32'(row_idx_q) / ROWS_PER_GRP);

   matrix_row_decode #(
      .ROWS        (ROWS),
      .ROW_ACT_LOW (ROW_ACT_LOW)
   ) u_row_decode (
      .idx   (row_idx_q),
      .drive (state_q == DRIVE),
      .sel   (row_sel)
   );

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: three configurations under shared rst/en, checked against a timeline model.
module tb_matrix_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   always #5 clk = ~clk;

   logic [2:0] m_idx, f_idx, l_idx;
   logic [7:0] m_sel, f_sel, l_sel;
   logic [1:0] m_grp, f_grp, l_grp;
   logic       m_blk, f_blk, l_blk;
   logic       m_fs,  f_fs,  l_fs;

   matrix_scan_ctrl #(.ROWS(8), .COL_GRPS(4), .DWELL(4), .BLANK(2), .ROW_ACT_LOW(1'b0)) u_main (
      .clk(clk), .rst(rst), .en(en), .row_idx(m_idx), .row_sel(m_sel),
      .col_grp(m_grp), .blank(m_blk), .frame_start(m_fs));

   matrix_scan_ctrl #(.ROWS(8), .COL_GRPS(4), .DWELL(1), .BLANK(0), .ROW_ACT_LOW(1'b0)) u_fast (
      .clk(clk), .rst(rst), .en(en), .row_idx(f_idx), .row_sel(f_sel),
      .col_grp(f_grp), .blank(f_blk), .frame_start(f_fs));

   matrix_scan_ctrl #(.ROWS(8), .COL_GRPS(4), .DWELL(4), .BLANK(2), .ROW_ACT_LOW(1'b1)) u_low (
      .clk(clk), .rst(rst), .en(en), .row_idx(l_idx), .row_sel(l_sel),
      .col_grp(l_grp), .blank(l_blk), .frame_start(l_fs));

   typedef struct {
      logic [2:0] idx;
      logic [1:0] grp;
      logic       blank;
      logic       fs;
      logic [7:0] sel;
   } exp_t;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned k        = 0;   // consecutive edges with rst=0 and en=1

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (k=%0d, t=%0t)", tag, obs, exp, k, $time);
   endtask

   // Expected outputs from elapsed scan time: each row owns BLANK gap clocks then DWELL drive clocks.
   function automatic exp_t model(input int unsigned kk, input int unsigned dwell,
                                  input int unsigned blnk, input bit low);
      exp_t        e;
      int unsigned p, period, row, phase;
      e.idx = '0; e.grp = '0; e.blank = 1'b1; e.fs = 1'b0; e.sel = '0;
      if (kk > 0) begin
         p      = kk - 1;
         period = dwell + blnk;
         row    = (p / period) % 8;
         phase  = p % period;
         e.idx  = 3'(row);
         e.grp  = 2'(row / 2);
         if (phase >= blnk) begin
            e.blank    = 1'b0;
            e.fs       = (row == 0) && (phase == blnk);
            e.sel[row] = 1'b1;
         end
      end
      if (low) e.sel = ~e.sel;
      return e;
   endfunction

   task automatic check_inst(input string pfx, input exp_t e, input logic [2:0] idx,
                             input logic [1:0] grp, input logic blk, input logic fs,
                             input logic [7:0] sel, input bit low);
      logic [7:0] act;
      act = low ? ~sel : sel;
      check({pfx, ".row_idx"},     32'(idx), 32'(e.idx));
      check({pfx, ".col_grp"},     32'(grp), 32'(e.grp));
      check({pfx, ".blank"},       32'(blk), 32'(e.blank));
      check({pfx, ".frame_start"}, 32'(fs),  32'(e.fs));
      check({pfx, ".row_sel"},     32'(sel), 32'(e.sel));
      check({pfx, ".onehot"},      32'(($countones(act) <= 1) && !(blk && (act != '0))), 32'd1);
   endtask

   task automatic step(input logic r, input logic e);
      rst = r;
      en  = e;
      @(posedge clk);
      #1;
      if (r || !e) k = 0;
      else k++;
      check_inst("main", model(k, 4, 2, 1'b0), m_idx, m_grp, m_blk, m_fs, m_sel, 1'b0);
      check_inst("fast", model(k, 1, 0, 1'b0), f_idx, f_grp, f_blk, f_fs, f_sel, 1'b0);
      check_inst("low",  model(k, 4, 2, 1'b1), l_idx, l_grp, l_blk, l_fs, l_sel, 1'b1);
   endtask

   exp_t cur;
   bit   found;

   initial begin
      // Reset state.
      repeat (3) step(1'b1, 1'b0);

      // Release with en high and scan more than two full frames.
      repeat (110) step(1'b0, 1'b1);

      // Drop en for one clock while row 5 is being driven, then restart.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cur = model(k, 4, 2, 1'b0);
         if (cur.idx == 3'd5 && !cur.blank) found = 1'b1;
         else step(1'b0, 1'b1);
      end
      check("reach_row5_drive", 32'(found), 32'd1);
      step(1'b0, 1'b0);
      repeat (60) step(1'b0, 1'b1);

      // Reset during the gap before row 3.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         cur = model(k, 4, 2, 1'b0);
         if (k > 0 && cur.idx == 3'd3 && cur.blank) found = 1'b1;
         else step(1'b0, 1'b1);
      end
      check("reach_row3_blank", 32'(found), 32'd1);
      step(1'b1, 1'b1);
      repeat (30) step(1'b0, 1'b1);

      // Random rst/en traffic.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) != 0));
      end
      repeat (60) step(1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/matrix_scan_ctrl.md
MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 Parameter ROWS, default 8: number of matrix rows scanned; SHALL be >= 2.
REQ-002 Parameter COL_GRPS, default 4: number of column groups; SHALL divide ROWS exactly.
REQ-003 Parameter DWELL, default 16: clocks each row is driven; SHALL be >= 1.
REQ-004 Parameter BLANK, default 2: all-rows-off clocks before each row; SHALL be >= 0.
REQ-005 Parameter ROW_ACT_LOW, default 0: 1 inverts every row_sel bit at the output.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  scan enable; 0 forces idle.
REQ-009 row_idx  output  clog2(ROWS)  index of the current or next row.
REQ-010 row_sel  output  ROWS  one-hot row drive, gated by state and polarity.
REQ-011 col_grp  output  clog2(COL_GRPS)  column group for row_idx.
REQ-012 blank  output  1  high when no row is driven.
REQ-013 frame_start  output  1  one-clock pulse at the start of row 0's drive.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BLNK and DRIVE.
REQ-015 IDLE: row_idx=0, blank=1, row_sel all inactive; the FSM SHALL go to BLNK when en=1 (or to DRIVE when BLANK=0).
REQ-016 BLNK: a counter SHALL run for exactly BLANK clocks with blank=1 and row_sel inactive, then go to DRIVE.
REQ-017 DRIVE: row_sel bit row_idx SHALL be active for exactly DWELL clocks with blank=0, then go to BLNK (or DRIVE when BLANK=0).
REQ-018 On leaving DRIVE, row_idx SHALL increment, wrapping ROWS-1 -> 0 with no invalid index ever output.
REQ-019 col_grp SHALL equal row_idx / (ROWS/COL_GRPS), combinationally from registered row_idx.
REQ-020 frame_start SHALL be 1 only on the first DRIVE clock of row 0, including the first row after IDLE.
REQ-021 Row period SHALL be DWELL+BLANK clocks; frame period SHALL be ROWS*(DWELL+BLANK) clocks.
REQ-022 en=0 in any state SHALL return the FSM to IDLE on the next edge: row_idx=0, counters cleared, all rows off.
REQ-023 No two row_sel bits SHALL ever be active together, and no row SHALL be active while blank=1.
REQ-024 Counters SHALL be sized by clog2 of their limits and SHALL never exceed DWELL-1 or BLANK-1.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL enter IDLE with row_idx=0, col_grp=0, blank=1, frame_start=0, row_sel inactive and counters 0.
REQ-026 rst SHALL take priority over en; asserting rst mid-row SHALL abort that row on the same edge.
REQ-027 Once rst deasserts with en=1, the first active row_sel SHALL appear BLANK+1 clocks later.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, BLNK, DRIVE) and the clog2-based width helpers.
REQ-029 The ROWS-wide one-hot decoder, including polarity inversion, SHALL be one sub-module, matrix_row_decode.
REQ-030 All outputs except col_grp and row_sel SHALL be registered.

Verification
Defaults for all scenarios: ROWS=8, COL_GRPS=4, DWELL=4, BLANK=2, ROW_ACT_LOW=0.
REQ-031 Release rst with en=1 -> blank=1 for 2 clocks, then row_sel=8'b00000001 for 4 clocks; frame_start is 1 on the first of those 4.
REQ-032 Run 48 clocks -> row_idx steps 0..7 then back to 0; col_grp follows 0,0,1,1,2,2,3,3; frame_start pulses recur every 48 clocks.
REQ-033 Drop en for 1 clock during row 5 DRIVE -> next edge IDLE with row_sel=0 and row_idx=0; restart resumes at row 0 with frame_start.
REQ-034 Assert rst during BLNK before row 3 -> outputs equal reset values on the next edge; no row 3 pulse appears.
REQ-035 With BLANK=0 and DWELL=1 -> row_sel shifts one bit per clock, blank never 1 while en=1, and frame_start pulses every 8 clocks.
REQ-036 With ROW_ACT_LOW=1 -> the active row reads 0, all others read 1, and the idle value is 8'hFF; a one-hot checker is enabled in every scenario.
